// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB
// first, behind a start/busy/done handshake. Each bit is formed by two
// half-subtractor cells plus an OR. The borrow between bits is held in a
// flop.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; diff/borrow_out hold the last result
// RUN   | one operand bit consumed per edge, WIDTH edges in total
// DONE  | single cycle with done high, then back to IDLE
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bff_q, bff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             h1;
    logic             d_bit;
    logic             bnext;

    // One full-subtractor bit slice on the current LSBs and the carried borrow.
    always_comb begin
        h1    = sa_q[0] ^ sb_q[0];
        d_bit = h1 ^ bff_q;
        bnext = (~sa_q[0] & sb_q[0]) | (~h1 & bff_q);
    end

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        bff_d        = bff_q;
        borrow_out_d = borrow_out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bff_d   = borrow_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                bff_d = bnext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Counter wraps here on power-of-two widths; it is
                    // reloaded on the next acceptance, so that is harmless.
                    diff_d       = {d_bit, res_q[WIDTH-1:1]};
                    borrow_out_d = bnext;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            bff_q        <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            bff_q        <= bff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing A − B − borrow_in, LSB first, one bit per clock.
- The datapath per bit is two half-subtractor cells plus an OR, with the borrow carried between bits in a flip-flop.
- It is the sequential stage that consumes half-subtractor outputs and produces a full-width difference.
- Used where area matters more than latency; a start/busy/done handshake interfaces it to a controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is updated.
- diff  output  WIDTH  result (a − b − borrow_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst high at an edge): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, borrow FF and bit counter = 0. Reset overrides all other inputs and aborts any operation in progress; no done pulse is produced.
- States:
  - IDLE: start=1 at an edge → load sa=a, sb=b, bff=borrow_in, cnt=0, clear the result shift register → RUN. start=0 → stay in IDLE.
  - RUN: at each edge, using sa[0], sb[0] and bff:
    - h1 = sa[0]^sb[0]; d = h1^bff.
    - bnext = (~sa[0]&sb[0]) | (~h1&bff).
    - Shift d into the result shift register from the MSB side; shift sa and sb right by 1; bff←bnext; cnt←cnt+1.
    - On the edge where cnt==WIDTH−1 (the final bit): diff←completed result, borrow_out←bnext, done←1, state→DONE.
  - DONE: one cycle only. done=1; at the next edge done←0, state→IDLE. start in DONE is ignored.
- busy = (state==RUN), registered.
- Latency: if start is sampled at edge E0, done is high for the cycle following edge E_WIDTH, i.e. WIDTH cycles after acceptance. Minimum issue interval is WIDTH+2 cycles.
- start while busy or in DONE is ignored. Operands captured at acceptance are unaffected by later changes on a, b or borrow_in.
- diff and borrow_out change only on the done edge. They hold their last value through IDLE and through a subsequent RUN until that run completes.
- Arithmetic: modulo 2^WIDTH. borrow_out is the unsigned borrow out of the MSB. No signed overflow flag.
- Counter width is clog2(WIDTH) bits; cnt never wraps during RUN because the state exits at WIDTH−1.
- No X on outputs after the first reset edge.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, borrow_in=0, start pulse → busy for 8 cycles, done pulse 8 cycles after acceptance; diff=0x23, borrow_out=0.
- a=0x12, b=0x35, borrow_in=0 → diff=0xDD, borrow_out=1.
- a=0x00, b=0x01, borrow_in=0 → diff=0xFF, borrow_out=1 (full borrow ripple). a=0x80, b=0x7F, borrow_in=1 → diff=0x00, borrow_out=0.
- Complete a=0x35, b=0x12. Start a=0xFF, b=0x01, then hold start=1 and change a and b during RUN → a single done; diff=0xFE, borrow_out=0. diff holds 0x23 until that done edge.
- Assert rst at the 4th RUN cycle → next cycle busy=0, done=0, diff=0, borrow_out=0, state IDLE, no done pulse; a fresh start of 0x35−0x12 then completes normally with 0x23.
- Sweep all a, b in 0..255 with borrow_in in {0,1} against a reference model → exact diff and borrow_out match; done count equals start-accept count.
